// File: rtl/data_mem_responder_if.sv
//============================================================================
// Module  : data_mem_responder_if
// Brief   : Load/store request bus between the datapath and the responder.
// Revision: 1.0
//============================================================================
`default_nettype none

interface data_mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              mem_read;
  logic              mem_write;
  logic [15:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              stall;
  logic              done;
  logic              err;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, stall, done, err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, stall, done, err
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_responder.sv
//============================================================================
// Module  : data_mem_responder
// Brief   : Multi-cycle word memory servicing datapath loads/stores with
//           configurable wait states, pipeline stall and done/err pulse.
// Revision: 1.0
//============================================================================
`default_nettype none

module data_mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  wire                       clk,
  input  wire                       rst_n,
  data_mem_responder_if.slave       bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_idx;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_done;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_req;
  logic                w_range_bad;
  logic                w_bad;

  // Requests are invisible while reset is held so stall stays low.
  assign w_req = rst_n & (bus.mem_read | bus.mem_write);

  generate
    if (ADDR_W < 15) begin : g_range
      assign w_range_bad = |bus.addr[15:ADDR_W+1];
    end else begin : g_full
      assign w_range_bad = 1'b0;
    end
  endgenerate

  assign w_bad = (bus.mem_read & bus.mem_write) | bus.addr[0] | w_range_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_bad)                 w_next = S_DONE;
          else if (WAIT_CYCLES == 0) w_next = S_ACCESS;
          else                       w_next = S_WAIT;
        end
      end
      S_WAIT:   if (r_cnt == 4'd1) w_next = S_ACCESS;
      S_ACCESS: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // done/err come straight from flops so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= (w_next == S_DONE);
      r_err  <= (w_next == S_DONE) && (r_state == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_req && !w_bad) begin
            r_wr    <= bus.mem_write;
            r_idx   <= bus.addr[ADDR_W:1];
            r_wdata <= bus.wdata;
            r_cnt   <= 4'(WAIT_CYCLES);
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd1) r_cnt <= r_cnt - 4'd1;
        end
        S_ACCESS: begin
          if (!r_wr) r_rdata <= r_mem[r_idx];
        end
        default: ;
      endcase
    end
  end

  // Array is deliberately not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS && r_wr) r_mem[r_idx] <= r_wdata;
  end

  assign bus.stall = (r_state == S_IDLE && w_req) || (r_state == S_WAIT) ||
                     (r_state == S_ACCESS);
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
//============================================================================
// Module  : tb_data_mem_responder
// Brief   : Directed bench for data_mem_responder (WAIT_CYCLES 2 and 0).
// Revision: 1.0
//============================================================================
`default_nettype none

module tb_data_mem_responder;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  data_mem_responder_if #(.DATA_W(16), .ADDR_W(8)) bus_a ();
  data_mem_responder_if #(.DATA_W(16), .ADDR_W(8)) bus_b ();

  data_mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  data_mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [15:0] d);
    if (sel == 0) begin
      bus_a.mem_read = rd; bus_a.mem_write = wr; bus_a.addr = a; bus_a.wdata = d;
    end else begin
      bus_b.mem_read = rd; bus_b.mem_write = wr; bus_b.addr = a; bus_b.wdata = d;
    end
  endtask

  function automatic logic get_stall(input int sel);
    return (sel == 0) ? bus_a.stall : bus_b.stall;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel == 0) ? bus_a.done : bus_b.done;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? bus_a.err : bus_b.err;
  endfunction
  function automatic logic [15:0] get_rdata(input int sel);
    return (sel == 0) ? bus_a.rdata : bus_b.rdata;
  endfunction

  // Request presented in cycle 0; stall expected for len cycles, done in cycle len.
  task automatic run_op(input string tag, input int sel, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d, input int len,
                        input logic exp_err, input logic [15:0] exp_rd, input bit keep);
    @(posedge clk); #1;
    set_req(sel, rd, wr, a, d);
    #1;
    for (int c = 0; c < len; c++) begin
      if (c > 0) begin @(posedge clk); #2; end
      chk({tag, "_stall"}, 32'(get_stall(sel)), 32'd1);
      chk({tag, "_nodone"}, 32'(get_done(sel)), 32'd0);
    end
    @(posedge clk); #2;
    chk({tag, "_stall_done"}, 32'(get_stall(sel)), 32'd0);
    chk({tag, "_done"}, 32'(get_done(sel)), 32'd1);
    chk({tag, "_err"}, 32'(get_err(sel)), 32'(exp_err));
    chk({tag, "_rdata"}, 32'(get_rdata(sel)), 32'(exp_rd));
    if (!keep) set_req(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    set_req(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    set_req(1, 1'b0, 1'b0, 16'h0000, 16'h0000);

    repeat (3) @(posedge clk);
    #2;
    chk("rst_stall", 32'(bus_a.stall), 32'd0);
    chk("rst_done", 32'(bus_a.done), 32'd0);
    chk("rst_err", 32'(bus_a.err), 32'd0);
    chk("rst_rdata", 32'(bus_a.rdata), 32'h0);
    set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("wr_beef", 0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 4, 1'b0, 16'h0000, 1'b0);
    run_op("rd_beef", 0, 1'b1, 1'b0, 16'h0010, 16'h0000, 4, 1'b0, 16'hBEEF, 1'b0);
    run_op("wr_5555", 0, 1'b0, 1'b1, 16'h0020, 16'h5555, 4, 1'b0, 16'hBEEF, 1'b0);
    run_op("err_misal", 0, 1'b1, 1'b0, 16'h0011, 16'h0000, 1, 1'b1, 16'hBEEF, 1'b0);
    run_op("err_range", 0, 1'b0, 1'b1, 16'h0200, 16'hDEAD, 1, 1'b1, 16'hBEEF, 1'b0);
    run_op("err_both", 0, 1'b1, 1'b1, 16'h0010, 16'h0BAD, 1, 1'b1, 16'hBEEF, 1'b0);
    run_op("rd_after_err", 0, 1'b1, 1'b0, 16'h0010, 16'h0000, 4, 1'b0, 16'hBEEF, 1'b0);
    run_op("rd_5555", 0, 1'b1, 1'b0, 16'h0020, 16'h0000, 4, 1'b0, 16'h5555, 1'b0);

    // Abort a store in its first WAIT cycle.
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b1, 16'h0020, 16'h1234);
    #1;
    chk("abort_stall0", 32'(bus_a.stall), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    chk("abort_stall", 32'(bus_a.stall), 32'd0);
    chk("abort_done0", 32'(bus_a.done), 32'd0);
    repeat (2) begin
      @(posedge clk); #2;
      chk("abort_nodone", 32'(bus_a.done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      chk("abort_idle_done", 32'(bus_a.done), 32'd0);
    end
    run_op("rd_abort", 0, 1'b1, 1'b0, 16'h0020, 16'h0000, 4, 1'b0, 16'h5555, 1'b0);

    // Held request: second access begins in the IDLE cycle after DONE.
    run_op("held1", 0, 1'b1, 1'b0, 16'h0010, 16'h0000, 4, 1'b0, 16'hBEEF, 1'b1);
    run_op("held2", 0, 1'b1, 1'b0, 16'h0010, 16'h0000, 4, 1'b0, 16'hBEEF, 1'b0);
    @(posedge clk); #2;
    chk("held_idle_stall", 32'(bus_a.stall), 32'd0);
    chk("held_idle_done", 32'(bus_a.done), 32'd0);

    // Zero-wait instance.
    run_op("z_wr", 1, 1'b0, 1'b1, 16'h0004, 16'hA5A5, 2, 1'b0, 16'h0000, 1'b0);
    run_op("z_rd", 1, 1'b1, 1'b0, 16'h0004, 16'h0000, 2, 1'b0, 16'hA5A5, 1'b0);
    run_op("z_err", 1, 1'b1, 1'b0, 16'h0005, 16'h0000, 1, 1'b1, 16'hA5A5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
